dpi_stream_dispatcher: RTL and testbench

// Upstream feeder for the per-regex matcher bank. Takes byte-wide packets carrying a

---
 rtl/dpi_stream_dispatcher.sv | 114 +++++++++++
 tb/tb_dpi_stream_dispatcher.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_dispatcher.sv
// dpi_stream_dispatcher: maps flow keys to stream slots and drives the matcher-side load/char/eop protocol
module dpi_stream_dispatcher #(
    parameter int NUM_STREAMS = 64,
    parameter int KEY_W       = 32,
    parameter int LOAD_GAP    = 2,
    parameter int EOP_GAP     = 3,
    parameter int DEFAULT_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sop,
    input  logic             s_eop,
    input  logic [KEY_W-1:0] s_key,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic             cfg_en,
    output logic [5:0]       stream_id,
    output logic             new_stream_id,
    output logic             load_state,
    output logic [7:0]       char_out,
    output logic             char_vld,
    output logic             eop,
    output logic             enable,
    output logic [15:0]      pkt_count,
    output logic [15:0]      drop_count
);
    typedef enum logic [2:0] {IDLE, SEARCH, LOAD, GAP, STREAM, DRAIN, EOP} state_t;
    state_t state, state_nxt;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] keys [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid, en;
    logic [5:0] cnt, victim, free_idx, alloc_idx;
    logic free_found, en_q, hit, last, alloc, beat, drop;

    assign hit       = state == SEARCH && valid[cnt] && keys[cnt] == key_q;
    assign last      = cnt == 6'(NUM_STREAMS - 1);
    assign alloc     = state == SEARCH && last && !hit;
    assign alloc_idx = free_found ? free_idx : !valid[cnt] ? cnt : victim;
    assign beat      = state == STREAM && s_valid;
    assign drop      = state == IDLE && s_valid && !s_sop;
    assign s_ready   = state == STREAM || drop;
    assign load_state = state == LOAD;
    assign eop       = state == EOP;
    assign enable    = state == EOP && en_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = s_valid && s_sop ? SEARCH : IDLE;
            SEARCH:  state_nxt = hit || last ? LOAD : SEARCH;
            LOAD:    state_nxt = LOAD_GAP > 1 ? GAP : STREAM;
            GAP:     state_nxt = cnt == 6'(LOAD_GAP - 2) ? STREAM : GAP;
            STREAM:  state_nxt = beat && s_eop ? DRAIN : STREAM;
            DRAIN:   state_nxt = cnt == 6'(EOP_GAP) ? EOP : DRAIN;
            EOP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            valid         <= '0;
            victim        <= '0;
            free_found    <= 1'b0;
            free_idx      <= '0;
            key_q         <= '0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            en_q          <= 1'b0;
            char_out      <= '0;
            char_vld      <= 1'b0;
            pkt_count     <= '0;
            drop_count    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= state_nxt != state ? '0 : cnt + 6'd1;
            char_vld <= beat;
            if (beat) char_out <= s_data;
            if (state == IDLE) free_found <= 1'b0;
            if (state == IDLE && s_valid && s_sop) key_q <= s_key;
            if (state == SEARCH && !valid[cnt] && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= cnt;
            end
            if (hit) begin
                stream_id     <= cnt;
                new_stream_id <= 1'b0;
            end
            if (alloc) begin
                stream_id          <= alloc_idx;
                new_stream_id      <= 1'b1;
                valid[alloc_idx]   <= 1'b1;
                if (!free_found && valid[cnt]) victim <= victim + 6'd1;
            end
            if (state == LOAD) en_q <= en[stream_id];
            if (state == EOP) pkt_count <= pkt_count + 16'd1;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // allocation is written after cfg so it wins a same-slot collision
    always_ff @(posedge clk) begin
        if (cfg_we) en[cfg_addr] <= cfg_en;
        if (alloc) begin
            keys[alloc_idx] <= key_q;
            en[alloc_idx]   <= DEFAULT_EN != 0;
        end
    end
endmodule

// File: tb/tb_dpi_stream_dispatcher.sv
// tb_dpi_stream_dispatcher: directed checks of lookup, allocation, timing and reset behaviour
module tb_dpi_stream_dispatcher;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  s_data = 0;
    logic        s_valid = 0, s_sop = 0, s_eop = 0, s_ready;
    logic [31:0] s_key = 0;
    logic        cfg_we = 0, cfg_en = 0;
    logic [5:0]  cfg_addr = 0, stream_id;
    logic        new_stream_id, load_state, char_vld, eop, enable;
    logic [7:0]  char_out;
    logic [15:0] pkt_count, drop_count;

    dpi_stream_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_sop(s_sop), .s_eop(s_eop), .s_key(s_key), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_en(cfg_en), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .load_state(load_state), .char_out(char_out), .char_vld(char_vld), .eop(eop),
        .enable(enable), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0, checks = 0, errs = 0, pkts_sent = 0, sop_cyc = 0;
    int load_cyc, n_load, eop_cyc, n_eop;
    logic [5:0] ld_id, eop_id;
    logic ld_new, eop_en;
    logic [7:0] chars[$];
    int char_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (load_state) begin load_cyc = cyc; ld_id = stream_id; ld_new = new_stream_id; n_load++; end
        if (char_vld) begin chars.push_back(char_out); char_cyc.push_back(cyc); end
        if (eop) begin eop_cyc = cyc; eop_en = enable; eop_id = stream_id; n_eop++; end
    end

    task automatic clear_mon();
        n_load = 0; n_eop = 0; load_cyc = -1; eop_cyc = -1;
        chars.delete(); char_cyc.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic sop, input logic lst, input logic [31:0] key);
        logic acc;
        int t;
        acc = 0; t = 0;
        s_valid = 1; s_data = d; s_sop = sop; s_eop = lst; s_key = key;
        while (!acc && t < 300) begin
            @(negedge clk); acc = s_ready;
            step(1); t++;
        end
        s_valid = 0; s_sop = 0; s_eop = 0;
        if (!acc) begin checks++; errs++; $display("FAIL beat_timeout ready=0 required=1"); end
    endtask

    task automatic wait_eop();
        int t;
        t = 0;
        while (n_eop == 0 && t < 200) begin step(1); t++; end
        checks++;
        if (n_eop == 0) begin errs++; $display("FAIL eop_timeout eop never seen"); end
        step(2);
    endtask

    task automatic send_pkt(input logic [31:0] key, input int len, input logic [7:0] base, input logic [15:0] gaps);
        clear_mon();
        sop_cyc = cyc;
        for (int i = 0; i < len; i++) begin
            if (gaps[i]) step(1);
            beat(base + 8'(i), i == 0, i == len - 1, key);
        end
        wait_eop();
        pkts_sent++;
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({s_ready, stream_id, new_stream_id, load_state, char_out, char_vld, eop, enable, pkt_count, drop_count} !== '0) begin
            errs++; $display("FAIL reset_outputs got nonzero outputs, required all 0");
        end
        rst_n = 1;
        step(1);
    endtask

    task automatic test_basic();
        send_pkt(32'hA, 3, 8'h61, 16'h0);
        checks++; if (ld_id !== 6'd0 || ld_new !== 1'b1) begin errs++; $display("FAIL basic_load id=%0d new=%0b required id=0 new=1", ld_id, ld_new); end
        checks++; if (load_cyc - sop_cyc !== 65) begin errs++; $display("FAIL basic_miss_latency got %0d required 65", load_cyc - sop_cyc); end
        checks++; if (chars.size() !== 3) begin errs++; $display("FAIL basic_nchars got %0d required 3", chars.size()); end
        else begin
            checks++; if ({chars[0], chars[1], chars[2]} !== {8'h61, 8'h62, 8'h63}) begin errs++; $display("FAIL basic_chars got %h %h %h required 61 62 63", chars[0], chars[1], chars[2]); end
            checks++; if (char_cyc[0] - load_cyc !== 3 || char_cyc[2] - char_cyc[0] !== 2) begin errs++; $display("FAIL basic_char_timing first=+%0d span=%0d required +3 and 2", char_cyc[0] - load_cyc, char_cyc[2] - char_cyc[0]); end
            checks++; if (eop_cyc - char_cyc[2] !== 4) begin errs++; $display("FAIL basic_eop_gap got %0d required 4", eop_cyc - char_cyc[2]); end
        end
        checks++; if (eop_en !== 1'b1 || eop_id !== 6'd0) begin errs++; $display("FAIL basic_eop enable=%0b id=%0d required 1 and 0", eop_en, eop_id); end
        checks++; if (pkt_count !== 16'd1) begin errs++; $display("FAIL basic_pkt_count got %0d required 1", pkt_count); end
    endtask

    task automatic test_hit();
        send_pkt(32'hA, 2, 8'h70, 16'h0);
        checks++; if (ld_id !== 6'd0 || ld_new !== 1'b0) begin errs++; $display("FAIL hit_load id=%0d new=%0b required id=0 new=0", ld_id, ld_new); end
        checks++; if (load_cyc - sop_cyc !== 2) begin errs++; $display("FAIL hit_latency got %0d required 2", load_cyc - sop_cyc); end
    endtask

    task automatic test_fill();
        for (int i = 1; i < 64; i++) begin
            send_pkt(32'h100 + i, 1, 8'(i), 16'h0);
            checks++; if (ld_id !== 6'(i) || ld_new !== 1'b1) begin errs++; $display("FAIL fill_slot%0d id=%0d new=%0b required id=%0d new=1", i, ld_id, ld_new, i); end
        end
        send_pkt(32'hFF, 1, 8'h01, 16'h0);
        checks++; if (ld_id !== 6'd0 || ld_new !== 1'b1) begin errs++; $display("FAIL victim_first id=%0d new=%0b required id=0 new=1", ld_id, ld_new); end
        checks++; if (load_cyc - sop_cyc !== 65) begin errs++; $display("FAIL victim_latency got %0d required 65", load_cyc - sop_cyc); end
        send_pkt(32'hA, 1, 8'h02, 16'h0);
        checks++; if (ld_id !== 6'd1 || ld_new !== 1'b1) begin errs++; $display("FAIL victim_second id=%0d new=%0b required id=1 new=1", ld_id, ld_new); end
    endtask

    task automatic test_cfg();
        cfg_we = 1; cfg_addr = 6'd0; cfg_en = 0;
        step(1);
        cfg_we = 0;
        send_pkt(32'hFF, 2, 8'h40, 16'h0);
        checks++; if (ld_id !== 6'd0 || ld_new !== 1'b0) begin errs++; $display("FAIL cfg_hit id=%0d new=%0b required id=0 new=0", ld_id, ld_new); end
        checks++; if (eop_en !== 1'b0) begin errs++; $display("FAIL cfg_enable_off got %0b required 0", eop_en); end
        send_pkt(32'hA, 2, 8'h50, 16'h0);
        checks++; if (ld_id !== 6'd1 || eop_en !== 1'b1 || load_cyc - sop_cyc !== 3) begin errs++; $display("FAIL cfg_other_slot id=%0d en=%0b lat=%0d required 1 1 3", ld_id, eop_en, load_cyc - sop_cyc); end
    endtask

    task automatic test_bubbles();
        send_pkt(32'hA, 4, 8'h30, 16'b0100);
        checks++; if (chars.size() !== 4) begin errs++; $display("FAIL bubble_nchars got %0d required 4", chars.size()); end
        else begin
            checks++; if (char_cyc[1] - char_cyc[0] !== 1 || char_cyc[2] - char_cyc[1] !== 2 || char_cyc[3] - char_cyc[2] !== 1) begin
                errs++; $display("FAIL bubble_timing deltas %0d %0d %0d required 1 2 1", char_cyc[1] - char_cyc[0], char_cyc[2] - char_cyc[1], char_cyc[3] - char_cyc[2]);
            end
            checks++; if (chars[2] !== 8'h32 || chars[3] !== 8'h33) begin errs++; $display("FAIL bubble_chars got %h %h required 32 33", chars[2], chars[3]); end
            checks++; if (eop_cyc - char_cyc[3] !== 4) begin errs++; $display("FAIL bubble_eop_gap got %0d required 4", eop_cyc - char_cyc[3]); end
        end
        send_pkt(32'h55, 1, 8'h5A, 16'h0);
        checks++; if (chars.size() !== 1 || n_eop !== 1) begin errs++; $display("FAIL single_counts chars=%0d eops=%0d required 1 1", chars.size(), n_eop); end
        else begin
            checks++; if (chars[0] !== 8'h5A || eop_cyc - char_cyc[0] !== 4) begin errs++; $display("FAIL single_char got %h gap %0d required 5a gap 4", chars[0], eop_cyc - char_cyc[0]); end
        end
        checks++; if (ld_id !== 6'd2 || ld_new !== 1'b1) begin errs++; $display("FAIL single_victim id=%0d new=%0b required 2 1", ld_id, ld_new); end
        checks++; if (pkt_count !== 16'(pkts_sent)) begin errs++; $display("FAIL pkt_count got %0d required %0d", pkt_count, pkts_sent); end
    endtask

    task automatic test_drop();
        clear_mon();
        beat(8'hEE, 1'b0, 1'b0, 32'h0);
        step(3);
        checks++; if (drop_count !== 16'd1 || chars.size() !== 0 || n_load !== 0) begin
            errs++; $display("FAIL drop drop_count=%0d chars=%0d loads=%0d required 1 0 0", drop_count, chars.size(), n_load);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_mon();
        t = 0;
        s_valid = 1; s_sop = 1; s_eop = 0; s_key = 32'h77; s_data = 8'h11;
        while (chars.size() < 2 && t < 200) begin step(1); t++; end
        checks++; if (chars.size() < 2) begin errs++; $display("FAIL mid_stream_start chars=%0d required 2", chars.size()); end
        rst_n = 0; s_valid = 0; s_sop = 0;
        step(1);
        checks++;
        if ({s_ready, stream_id, new_stream_id, load_state, char_vld, eop, enable, pkt_count, drop_count} !== '0) begin
            errs++; $display("FAIL mid_reset_outputs got nonzero outputs, required all 0");
        end
        rst_n = 1;
        step(10);
        checks++; if (n_eop !== 0) begin errs++; $display("FAIL mid_reset_eop got %0d eops required 0", n_eop); end
        send_pkt(32'hFF, 1, 8'h01, 16'h0);
        checks++; if (ld_id !== 6'd0 || ld_new !== 1'b1) begin errs++; $display("FAIL table_cleared id=%0d new=%0b required 0 1", ld_id, ld_new); end
        checks++; if (pkt_count !== 16'd1 || eop_en !== 1'b1) begin errs++; $display("FAIL post_reset pkt_count=%0d en=%0b required 1 1", pkt_count, eop_en); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_hit();
        test_fill();
        test_cfg();
        test_bubbles();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
